// File: rtl/user_input_irq_ctrl.sv
// Debounced key/switch event capture with a masked level interrupt, exposed as an Avalon-MM slave.
// Keys are active-low and raise events only on press; switches raise events on both edges.
module user_input_irq_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  user_input_keys,
   input  logic [3:0]  user_input_switches,
   output logic        irq
);

   localparam logic [7:0]       IN_RST    = 8'h0F;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(DEBOUNCE_CYCLES + 2);
   localparam logic [1:0]       ADDR_DATA = 2'd0;
   localparam logic [1:0]       ADDR_MASK = 2'd1;
   localparam logic [1:0]       ADDR_EDGE = 2'd2;
   localparam logic [1:0]       ADDR_CNT  = 2'd3;

   logic [7:0]            in_s;
   logic [7:0]            sync1_q, sync2_q;
   logic [7:0]            stable_q, stable_d;
   logic [7:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]            ev_s;
   logic                  armed_q, armed_d;
   logic [CNT_W-1:0]      start_q, start_d;
   logic [7:0]            mask_q, mask_d;
   logic [7:0]            edge_q, edge_d;
   logic [7:0]            clr_s;
   logic                  cnt_clr_s;
   logic [15:0]           evcnt_q, evcnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  irq_q, irq_d;
   logic                  unused_s;

   assign in_s         = {user_input_switches, user_input_keys};
   assign avs_readdata = rdata_q;
   assign irq          = irq_q;
   assign unused_s     = ^avs_writedata[31:8];

   // Startup hold-off: stable tracks the pads until the counter has run out once.
   always_comb begin
      armed_d = armed_q;
      start_d = start_q;
      if (!armed_q) begin
         if (start_q == ARM_LAST) begin
            armed_d = 1'b1;
         end else begin
            start_d = start_q + CNT_W'(1);
         end
      end else begin
         start_d = start_q;
      end
   end

   // Per-bit debounce; an event is qualified at the moment stable takes the new value.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      ev_s     = 8'h00;
      if (!armed_q) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               cnt_d[i]    = '0;
               ev_s[i]     = (i >= 4) ? 1'b1 : ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Register file next state; set beats W1C clear, and an event beats a count clear.
   always_comb begin
      clr_s     = (avs_write && (avs_address == ADDR_EDGE)) ? avs_writedata[7:0] : 8'h00;
      cnt_clr_s = avs_write && (avs_address == ADDR_CNT);
      edge_d    = (edge_q & ~clr_s) | ev_s;
      mask_d    = (avs_write && (avs_address == ADDR_MASK)) ? avs_writedata[7:0] : mask_q;
      irq_d     = |(edge_q & mask_q);
      if (|ev_s) begin
         if (cnt_clr_s) begin
            evcnt_d = 16'd1;
         end else if (evcnt_q == 16'hFFFF) begin
            evcnt_d = evcnt_q;
         end else begin
            evcnt_d = evcnt_q + 16'd1;
         end
      end else if (cnt_clr_s) begin
         evcnt_d = 16'd0;
      end else begin
         evcnt_d = evcnt_q;
      end
      rdata_d = rdata_q;
      if (avs_read) begin
         case (avs_address)
            ADDR_DATA: rdata_d = {24'd0, stable_q};
            ADDR_MASK: rdata_d = {24'd0, mask_q};
            ADDR_EDGE: rdata_d = {24'd0, edge_q};
            ADDR_CNT:  rdata_d = {16'd0, evcnt_q};
            default:   rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q  <= IN_RST;
         sync2_q  <= IN_RST;
         stable_q <= IN_RST;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         start_q  <= '0;
         mask_q   <= 8'h00;
         edge_q   <= 8'h00;
         evcnt_q  <= 16'd0;
         rdata_q  <= 32'd0;
         irq_q    <= 1'b0;
      end else begin
         sync1_q  <= in_s;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         start_q  <= start_d;
         mask_q   <= mask_d;
         edge_q   <= edge_d;
         evcnt_q  <= evcnt_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

endmodule

// File: tb/tb_user_input_irq_ctrl.sv
// Bench for user_input_irq_ctrl: directed scenarios checked every cycle against a
// history-based model (a bit flips once its synchronized value has disagreed for D cycles).
module tb_user_input_irq_ctrl;

   localparam int D = 4;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  user_input_keys;
   logic [3:0]  user_input_switches;
   logic        irq;

   int total = 0;
   int bad   = 0;

   logic [7:0]  m_stable, m_mask, m_edge, m_p1, m_p2;
   logic [7:0]  m_yh [D];
   logic [15:0] m_cnt;
   logic [31:0] m_rdata;
   logic        m_irq;
   int          m_n;

   user_input_irq_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
      .clk_clk             (clk_clk),
      .reset_reset_n       (reset_reset_n),
      .avs_address         (avs_address),
      .avs_read            (avs_read),
      .avs_readdata        (avs_readdata),
      .avs_write           (avs_write),
      .avs_writedata       (avs_writedata),
      .user_input_keys     (user_input_keys),
      .user_input_switches (user_input_switches),
      .irq                 (irq)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_stable = 8'h0F;
      m_mask   = 8'h00;
      m_edge   = 8'h00;
      m_p1     = 8'h0F;
      m_p2     = 8'h0F;
      for (int k = 0; k < D; k++) m_yh[k] = 8'h0F;
      m_cnt    = 16'd0;
      m_rdata  = 32'd0;
      m_irq    = 1'b0;
      m_n      = 0;
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare outputs.
   task automatic tick();
      logic [7:0]  pad, y, nstab, ev, clr;
      logic        rd, wr, all_diff;
      logic [1:0]  a;
      logic [31:0] wd;
      pad = {user_input_switches, user_input_keys};
      rd  = avs_read;
      wr  = avs_write;
      a   = avs_address;
      wd  = avs_writedata;
      @(posedge clk_clk);
      if (reset_reset_n) begin
         m_n++;
         y    = m_p2;
         m_p2 = m_p1;
         m_p1 = pad;
         for (int k = D - 1; k > 0; k--) m_yh[k] = m_yh[k-1];
         m_yh[0] = y;
         nstab = m_stable;
         ev    = 8'h00;
         if (m_n < D + 4) begin
            nstab = y;
         end else begin
            for (int b = 0; b < 8; b++) begin
               all_diff = 1'b1;
               for (int k = 0; k < D; k++)
                  if (m_yh[k][b] == m_stable[b]) all_diff = 1'b0;
               if (all_diff) begin
                  nstab[b] = ~m_stable[b];
                  ev[b]    = (b < 4) ? m_stable[b] : 1'b1;
               end
            end
         end
         if (rd) begin
            case (a)
               2'd0:    m_rdata = {24'd0, m_stable};
               2'd1:    m_rdata = {24'd0, m_mask};
               2'd2:    m_rdata = {24'd0, m_edge};
               default: m_rdata = {16'd0, m_cnt};
            endcase
         end
         m_irq  = |(m_edge & m_mask);
         clr    = (wr && a == 2'd2) ? wd[7:0] : 8'h00;
         m_edge = (m_edge & ~clr) | ev;
         if (ev != 8'h00)
            m_cnt = (wr && a == 2'd3) ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
         else if (wr && a == 2'd3)
            m_cnt = 16'd0;
         if (wr && a == 2'd1) m_mask = wd[7:0];
         m_stable = nstab;
      end
      #1;
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      chk("readdata", avs_readdata, m_rdata);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      tick();
      avs_write     = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      tick();
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   initial begin
      logic [31:0] d;
      reset_reset_n       = 1'b0;
      user_input_keys     = 4'hF;
      user_input_switches = 4'b1010;
      avs_address         = 2'd0;
      avs_read            = 1'b0;
      avs_write           = 1'b0;
      avs_writedata       = 32'd0;
      model_reset();
      ticks(3);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      chk("reset_rdata", avs_readdata, 32'd0);
      reset_reset_n = 1'b1;

      // startup: levels visible, no events
      ticks(10);
      bus_rd(2'd0, d); chk("s1_data", d, 32'h0000_00AF);
      bus_rd(2'd2, d); chk("s1_edge", d, 32'd0);
      chk("s1_irq", {31'd0, irq}, 32'd0);

      // key0 press with mask bit0
      bus_wr(2'd1, 32'h1);
      user_input_keys = 4'hE;
      ticks(6);
      chk("s2_irq_pre", {31'd0, irq}, 32'd0);
      bus_rd(2'd2, d); chk("s2_edge", d, 32'h1);
      chk("s2_irq", {31'd0, irq}, 32'd1);
      user_input_keys = 4'hF;
      ticks(8);
      bus_rd(2'd2, d); chk("s2_release_edge", d, 32'h1);
      bus_rd(2'd3, d); chk("s2_count", d, 32'd1);
      bus_wr(2'd2, 32'h1);
      chk("s2_irq_wr", {31'd0, irq}, 32'd1);
      tick();
      chk("s2_irq_clr", {31'd0, irq}, 32'd0);

      // glitch on key1
      bus_wr(2'd3, 32'd0);
      user_input_keys = 4'hD;
      ticks(3);
      user_input_keys = 4'hF;
      ticks(8);
      bus_rd(2'd0, d); chk("s3_data", d, 32'h0000_00AF);
      bus_rd(2'd2, d); chk("s3_edge", d, 32'd0);
      bus_rd(2'd3, d); chk("s3_count", d, 32'd0);

      // sw2 both directions, unmasked
      bus_wr(2'd1, 32'd0);
      user_input_switches = 4'b1110;
      ticks(8);
      user_input_switches = 4'b1010;
      ticks(8);
      bus_rd(2'd2, d); chk("s4_edge", d, 32'h40);
      bus_rd(2'd3, d); chk("s4_count", d, 32'd2);
      chk("s4_irq", {31'd0, irq}, 32'd0);

      // event coinciding with W1C, then with count clear
      bus_wr(2'd2, 32'hFF);
      bus_rd(2'd2, d); chk("s5_edge_clr", d, 32'd0);
      user_input_switches = 4'b1110;
      ticks(5);
      bus_wr(2'd2, 32'h40);
      bus_rd(2'd2, d); chk("s5_edge_set_wins", d, 32'h40);
      user_input_switches = 4'b1010;
      ticks(5);
      bus_wr(2'd3, 32'd0);
      bus_rd(2'd3, d); chk("s5_count_one", d, 32'd1);

      // staggered switch toggling yields one event per cycle, driving the counter into saturation
      bus_wr(2'd3, 32'd0);
      for (int c = 0; c < 65600; c++) begin
         user_input_switches[c % 4] = ~user_input_switches[c % 4];
         tick();
      end
      ticks(10);
      bus_rd(2'd3, d); chk("s6_count_sat", d, 32'h0000_FFFF);

      // reset in the middle of a key debounce
      user_input_keys = 4'hB;
      ticks(3);
      reset_reset_n = 1'b0;
      model_reset();
      #1;
      chk("s6_rst_rdata", avs_readdata, 32'd0);
      chk("s6_rst_irq", {31'd0, irq}, 32'd0);
      user_input_keys     = 4'hF;
      user_input_switches = 4'h0;
      ticks(2);
      reset_reset_n = 1'b1;
      ticks(10);
      bus_rd(2'd0, d); chk("s6_data", d, 32'h0F);
      bus_rd(2'd1, d); chk("s6_mask", d, 32'd0);
      bus_rd(2'd2, d); chk("s6_edge", d, 32'd0);
      bus_rd(2'd3, d); chk("s6_count", d, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
